gpio_input_distributor: RTL

Input-side counterpart of the per-pin output/drive arbitration: takes the 32 raw GPIO pad inputs, synchronizes them into the core clock domain, and delivers a per-core rotated view of the pins, per-pin edge flags, and a per-core WAIT-on-pin matcher. It sits between the pad ring and the four PIO cores. All cores read the same synchronized pin state; there is no arbitration on the input direction.

---
 rtl/gpio_input_distributor.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gpio_input_distributor.sv
// gpio_input_distributor
// Brings the 32 raw pad inputs into the core clock domain. Each PIO core gets
// a rotated view of the pins and per-pin edge flags, and has its own
// wait-on-pin matcher. All cores see the same synchronized pin state.
//
// Wait FSM (one per core)
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no wait pending; accepts core_wait_req when cancel is low
//   ST_WAIT | compares pin_value[captured pin] to the captured polarity
module gpio_input_distributor #(
  parameter int NUM_CORES = 4,
  parameter int NUM_PINS  = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_PINS-1:0]                      gpio_input,
  input  logic [NUM_PINS-1:0]                      sync_bypass,
  input  logic [NUM_CORES-1:0][$clog2(NUM_PINS)-1:0] core_in_base,
  output logic [NUM_CORES-1:0][NUM_PINS-1:0]       core_input,
  output logic [NUM_PINS-1:0]                      pin_rise,
  output logic [NUM_PINS-1:0]                      pin_fall,
  input  logic [NUM_CORES-1:0]                     core_wait_req,
  input  logic [NUM_CORES-1:0][$clog2(NUM_PINS)-1:0] core_wait_pin,
  input  logic [NUM_CORES-1:0]                     core_wait_pol,
  input  logic [NUM_CORES-1:0]                     core_wait_cancel,
  output logic [NUM_CORES-1:0]                     core_wait_busy,
  output logic [NUM_CORES-1:0]                     core_wait_done
);

  localparam int PW = $clog2(NUM_PINS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_t;

  logic [NUM_PINS-1:0] sync1;
  logic [NUM_PINS-1:0] sync2;
  logic [NUM_PINS-1:0] pin_prev;
  logic [NUM_PINS-1:0] pin_value;
  logic                primed;

  wait_state_t                   state      [NUM_CORES];
  wait_state_t                   state_next [NUM_CORES];
  logic [NUM_CORES-1:0][PW-1:0]  wait_pin_q;
  logic [NUM_CORES-1:0]          wait_pol_q;
  logic [NUM_CORES-1:0]          capture;
  logic [NUM_CORES-1:0]          match;
  logic [NUM_CORES-1:0]          done_next;

  // Two-flop synchronizer, previous-value register for edge detect, and the
  // primed flag that masks edges in the first cycle out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      pin_prev <= '0;
      primed   <= 1'b0;
    end else begin
      sync1    <= gpio_input;
      sync2    <= sync1;
      pin_prev <= pin_value;
      primed   <= 1'b1;
    end
  end

  // Bypassed pins take the raw pad value without any added latency.
  assign pin_value = (sync_bypass & gpio_input) | (~sync_bypass & sync2);

  assign pin_rise = pin_value & ~pin_prev & {NUM_PINS{primed}};
  assign pin_fall = ~pin_value & pin_prev & {NUM_PINS{primed}};

  // Per-core rotate-right of the pin vector by core_in_base; the index wraps
  // naturally in PW bits.
  always_comb begin
    core_input = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int j = 0; j < NUM_PINS; j++) begin
        core_input[c][j] = pin_value[PW'(j + int'(core_in_base[c]))];
      end
    end
  end

  // Wait FSM next-state logic; cancel beats both a new request and a match.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      state_next[c] = state[c];
      capture[c]    = 1'b0;
      done_next[c]  = 1'b0;
      match[c]      = (pin_value[wait_pin_q[c]] == wait_pol_q[c]);
      case (state[c])
        ST_IDLE: begin
          if (core_wait_req[c] && !core_wait_cancel[c]) begin
            capture[c]    = 1'b1;
            state_next[c] = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (core_wait_cancel[c]) begin
            state_next[c] = ST_IDLE;
          end else if (match[c]) begin
            state_next[c] = ST_IDLE;
            done_next[c]  = 1'b1;
          end
        end
        default: state_next[c] = ST_IDLE;
      endcase
    end
  end

  // Wait FSM state, captured pin/polarity, and the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        state[c] <= ST_IDLE;
      end
      wait_pin_q     <= '0;
      wait_pol_q     <= '0;
      core_wait_done <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        state[c] <= state_next[c];
        if (capture[c]) begin
          wait_pin_q[c] <= core_wait_pin[c];
          wait_pol_q[c] <= core_wait_pol[c];
        end
      end
      core_wait_done <= done_next;
    end
  end

  // Busy is a direct decode of the registered state.
  always_comb begin
    core_wait_busy = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      core_wait_busy[c] = (state[c] == ST_WAIT);
    end
  end

endmodule
